// File: rtl/mst_strm_pkg.sv
// Shared encodings and constants for the stream generator.
package mst_strm_pkg;

  localparam int unsigned DEF_WIDTH  = 36;
  localparam int unsigned DEF_LENBIT = 16;

  // PRBS-31 polynomial x^31 + x^28 + 1 as register bit positions
  localparam int unsigned PRBS_LEN   = 31;
  localparam int unsigned PRBS_TAP_A = 30;
  localparam int unsigned PRBS_TAP_B = 27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_PRBS  = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

endpackage

// File: rtl/mst_strm_gen_if.sv
// Control and data bundle between the generator and its pre-fetch stage.
interface mst_strm_gen_if #(
  parameter int unsigned WIDTH  = 36,
  parameter int unsigned LENBIT = 16
) ();

  logic              gen_start;
  logic              gen_stop;
  logic [1:0]        gen_mode;
  logic [WIDTH-5:0]  gen_seed;
  logic [LENBIT-1:0] gen_len;
  logic              gen0req;
  logic [WIDTH-5:0]  gen0dat;
  logic              gen_busy;
  logic              gen_done;
  logic [LENBIT-1:0] gen_cnt;

  modport master (
    input  gen_start, gen_stop, gen_mode, gen_seed, gen_len, gen0req,
    output gen0dat, gen_busy, gen_done, gen_cnt
  );

  modport slave (
    output gen_start, gen_stop, gen_mode, gen_seed, gen_len, gen0req,
    input  gen0dat, gen_busy, gen_done, gen_cnt
  );

endinterface

// File: rtl/mst_pat_step.sv
// Combinational next-value function for each pattern mode.
module mst_pat_step
  import mst_strm_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  mode_e         mode,
  input  logic [DW-1:0] cur,
  output logic [DW-1:0] nxt
);

  // Select the pattern advance; constant mode keeps the value
  always_comb begin
    nxt = cur;
    case (mode)
      MODE_INC:  nxt = cur + DW'(1);
      MODE_PRBS: begin
        nxt = '0;
        nxt[PRBS_LEN-1:0] = {cur[PRBS_LEN-2:0], cur[PRBS_TAP_A] ^ cur[PRBS_TAP_B]};
      end
      MODE_WALK: nxt = {cur[DW-2:0], cur[DW-1]};
      default:   nxt = cur;
    endcase
  end

endmodule

// File: rtl/mst_strm_gen.sv
// Test-pattern stream generator: start/stop FSM, word counter and data register.
module mst_strm_gen
  import mst_strm_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned LENBIT = DEF_LENBIT
) (
  input  logic           clk,
  input  logic           rst_n,
  mst_strm_gen_if.master bus
);

  localparam int unsigned DW = WIDTH - 4;

  state_e            state_q;
  mode_e             mode_q;
  logic [LENBIT-1:0] len_q;
  logic [LENBIT-1:0] cnt_q;
  logic [DW-1:0]     dat_q;
  logic [DW-1:0]     nxt_q;
  logic              busy_q;
  logic              done_q;

  logic [DW-1:0]     seed_eff_c;
  logic [DW-1:0]     step_c;
  logic [LENBIT-1:0] cnt_inc_c;
  logic              last_word_c;

  mst_pat_step #(.DW(DW)) u_step (
    .mode (mode_q),
    .cur  (nxt_q),
    .nxt  (step_c)
  );

  // Seed as loaded at start: degenerate all-zero seeds would lock PRBS and walking-one
  always_comb begin
    seed_eff_c = bus.gen_seed;
    case (mode_e'(bus.gen_mode))
      MODE_PRBS: begin
        seed_eff_c = '0;
        if (bus.gen_seed[PRBS_LEN-1:0] == '0)
          seed_eff_c[PRBS_LEN-1:0] = PRBS_LEN'(1);
        else
          seed_eff_c[PRBS_LEN-1:0] = bus.gen_seed[PRBS_LEN-1:0];
      end
      MODE_WALK: if (bus.gen_seed == '0) seed_eff_c = DW'(1);
      default: ;
    endcase
  end

  // Bounded transfers end on the word that brings the count up to the length
  always_comb begin
    cnt_inc_c   = cnt_q + LENBIT'(1);
    last_word_c = bus.gen0req && (len_q != '0) && (cnt_inc_c == len_q);
  end

  // Control FSM with registered busy/done, plus the accept datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_INC;
      len_q   <= '0;
      cnt_q   <= '0;
      dat_q   <= '0;
      nxt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.gen_start && !bus.gen_stop) begin
            mode_q  <= mode_e'(bus.gen_mode);
            len_q   <= bus.gen_len;
            cnt_q   <= '0;
            nxt_q   <= seed_eff_c;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.gen0req) begin
            dat_q <= nxt_q;
            nxt_q <= step_c;
            cnt_q <= cnt_inc_c;
          end
          if (bus.gen_stop || last_word_c) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gen0dat  = dat_q;
  assign bus.gen_busy = busy_q;
  assign bus.gen_done = done_q;
  assign bus.gen_cnt  = cnt_q;

endmodule

// File: tb/tb_mst_strm_gen.sv
// Directed bench for mst_strm_gen: one task per scenario, inline checks.
module tb_mst_strm_gen;
  import mst_strm_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mst_strm_gen_if #(.WIDTH(36), .LENBIT(16)) bus ();

  mst_strm_gen #(.WIDTH(36), .LENBIT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [1:0] mode, input logic [31:0] seed, input logic [15:0] len);
    bus.gen_mode  = mode;
    bus.gen_seed  = seed;
    bus.gen_len   = len;
    bus.gen_start = 1'b1;
    tick();
    bus.gen_start = 1'b0;
  endtask

  task automatic test_reset();
    bus.gen_start = 1'b0;
    bus.gen_stop  = 1'b0;
    bus.gen_mode  = 2'd0;
    bus.gen_seed  = '0;
    bus.gen_len   = '0;
    bus.gen0req   = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_tests++;
    if (bus.gen0dat !== 32'h0 || bus.gen_cnt !== 16'h0 || bus.gen_busy !== 1'b0 || bus.gen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: dat=%h cnt=%0d busy=%b done=%b, required all 0",
               bus.gen0dat, bus.gen_cnt, bus.gen_busy, bus.gen_done);
    end
  endtask

  task automatic test_increment();
    logic [31:0] exp_dat;
    int          done_seen;
    done_seen = 0;
    start_xfer(2'd0, 32'h0000_0010, 16'd4);
    n_tests++;
    if (bus.gen_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL inc_busy_start: busy=%b required 1", bus.gen_busy);
    end
    bus.gen0req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.gen_done === 1'b1) done_seen++;
      exp_dat = 32'h0000_0010 + 32'(i);
      n_tests++;
      if (bus.gen0dat !== exp_dat) begin
        n_fail++;
        $display("FAIL inc_word%0d: dat=%h required %h", i, bus.gen0dat, exp_dat);
      end
    end
    bus.gen0req = 1'b0;
    n_tests++;
    if (bus.gen_busy !== 1'b0 || bus.gen_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL inc_end: busy=%b cnt=%0d required busy=0 cnt=4", bus.gen_busy, bus.gen_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.gen_done === 1'b1) done_seen++;
    end
    n_tests++;
    if (done_seen != 1 || bus.gen_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL inc_done_once: done pulses=%0d cnt=%0d required 1 and 4", done_seen, bus.gen_cnt);
    end
  endtask

  task automatic test_prbs();
    start_xfer(2'd1, 32'h0, 16'd0);
    bus.gen0req = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 1) begin
        n_tests++;
        if (bus.gen0dat !== 32'h0000_0001) begin
          n_fail++;
          $display("FAIL prbs_word1: dat=%h required 00000001", bus.gen0dat);
        end
      end
      if (i == 2) begin
        n_tests++;
        if (bus.gen0dat !== 32'h0000_0002) begin
          n_fail++;
          $display("FAIL prbs_word2: dat=%h required 00000002", bus.gen0dat);
        end
      end
      if (i == 28) begin
        n_tests++;
        if (bus.gen0dat !== 32'h0800_0000) begin
          n_fail++;
          $display("FAIL prbs_word28: dat=%h required 08000000", bus.gen0dat);
        end
      end
    end
    // 1<<27, then taps feed back: (1<<28)|1, (1<<29)|2, (1<<30)|4, 9
    n_tests++;
    if (bus.gen0dat !== 32'h0000_0009 || bus.gen_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL prbs_word32: dat=%h busy=%b required 00000009 busy=1", bus.gen0dat, bus.gen_busy);
    end
    bus.gen0req  = 1'b0;
    bus.gen_stop = 1'b1;
    tick();
    bus.gen_stop = 1'b0;
    n_tests++;
    if (bus.gen_done !== 1'b1 || bus.gen_cnt !== 16'd32 || bus.gen0dat !== 32'h0000_0009) begin
      n_fail++;
      $display("FAIL prbs_stop: done=%b cnt=%0d dat=%h required 1 32 00000009",
               bus.gen_done, bus.gen_cnt, bus.gen0dat);
    end
    tick();
  endtask

  task automatic test_walk();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h8000_0000;
    exp_w[1] = 32'h0000_0001;
    exp_w[2] = 32'h0000_0002;
    start_xfer(2'd2, 32'h8000_0000, 16'd3);
    bus.gen0req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus.gen0dat !== exp_w[i]) begin
        n_fail++;
        $display("FAIL walk_word%0d: dat=%h required %h", i, bus.gen0dat, exp_w[i]);
      end
    end
    bus.gen0req = 1'b0;
    n_tests++;
    if (bus.gen_done !== 1'b1 || bus.gen_busy !== 1'b0 || bus.gen_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL walk_end: done=%b busy=%b cnt=%0d required 1 0 3", bus.gen_done, bus.gen_busy, bus.gen_cnt);
    end
    tick();
  endtask

  task automatic test_stop_toggle();
    start_xfer(2'd0, 32'h0000_0100, 16'd0);
    for (int i = 0; i < 5; i++) begin
      bus.gen0req = 1'b1;
      tick();
      bus.gen0req = 1'b0;
      tick();
      n_tests++;
      if (bus.gen_cnt !== 16'(i + 1) || bus.gen0dat !== 32'h100 + 32'(i)) begin
        n_fail++;
        $display("FAIL toggle_hold%0d: cnt=%0d dat=%h required %0d %h",
                 i, bus.gen_cnt, bus.gen0dat, i + 1, 32'h100 + 32'(i));
      end
    end
    bus.gen0req  = 1'b1;
    bus.gen_stop = 1'b1;
    tick();
    bus.gen0req  = 1'b0;
    bus.gen_stop = 1'b0;
    n_tests++;
    if (bus.gen_cnt !== 16'd6 || bus.gen0dat !== 32'h105 || bus.gen_done !== 1'b1 || bus.gen_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_same_cycle: cnt=%0d dat=%h done=%b busy=%b required 6 105 1 0",
               bus.gen_cnt, bus.gen0dat, bus.gen_done, bus.gen_busy);
    end
    tick();
    n_tests++;
    if (bus.gen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_done_width: done=%b required 0", bus.gen_done);
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    done_seen = 0;
    start_xfer(2'd0, 32'h0000_0020, 16'd8);
    bus.gen0req = 1'b1;
    tick();
    tick();
    bus.gen0req = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++;
    if (bus.gen0dat !== 32'h0 || bus.gen_cnt !== 16'h0 || bus.gen_busy !== 1'b0 ||
        bus.gen_done !== 1'b0 || dut.state_q !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_mid: dat=%h cnt=%0d busy=%b done=%b state=%0d required 0 0 0 0 IDLE",
               bus.gen0dat, bus.gen_cnt, bus.gen_busy, bus.gen_done, dut.state_q);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.gen_done === 1'b1) done_seen++;
    end
    n_tests++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: done pulses=%0d required 0", done_seen);
    end
    start_xfer(2'd0, 32'h0000_0020, 16'd8);
    bus.gen0req = 1'b1;
    tick();
    bus.gen0req = 1'b0;
    n_tests++;
    if (bus.gen0dat !== 32'h0000_0020 || bus.gen_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_restart: dat=%h cnt=%0d required 00000020 1", bus.gen0dat, bus.gen_cnt);
    end
    bus.gen_stop = 1'b1;
    tick();
    bus.gen_stop = 1'b0;
    tick();
  endtask

  task automatic test_start_conflicts();
    bus.gen_mode  = 2'd3;
    bus.gen_seed  = 32'h0000_ABCD;
    bus.gen_len   = 16'd5;
    bus.gen_start = 1'b1;
    bus.gen_stop  = 1'b1;
    tick();
    bus.gen_start = 1'b0;
    bus.gen_stop  = 1'b0;
    tick();
    n_tests++;
    if (bus.gen_busy !== 1'b0 || bus.gen_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL start_stop_idle: busy=%b cnt=%0d required 0 1", bus.gen_busy, bus.gen_cnt);
    end
    start_xfer(2'd3, 32'h0000_ABCD, 16'd5);
    bus.gen0req = 1'b1;
    tick();
    tick();
    bus.gen0req   = 1'b0;
    bus.gen_start = 1'b1;
    tick();
    bus.gen_start = 1'b0;
    n_tests++;
    if (bus.gen_cnt !== 16'd2 || bus.gen_busy !== 1'b1 || bus.gen0dat !== 32'h0000_ABCD) begin
      n_fail++;
      $display("FAIL start_in_run: cnt=%0d busy=%b dat=%h required 2 1 0000abcd",
               bus.gen_cnt, bus.gen_busy, bus.gen0dat);
    end
    bus.gen0req = 1'b1;
    tick();
    tick();
    tick();
    bus.gen0req = 1'b0;
    n_tests++;
    if (bus.gen_cnt !== 16'd5 || bus.gen_done !== 1'b1 || bus.gen0dat !== 32'h0000_ABCD) begin
      n_fail++;
      $display("FAIL const_end: cnt=%0d done=%b dat=%h required 5 1 0000abcd",
               bus.gen_cnt, bus.gen_done, bus.gen0dat);
    end
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    test_reset();
    test_increment();
    test_prbs();
    test_walk();
    test_stop_toggle();
    test_reset_mid();
    test_start_conflicts();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mst_strm_gen.md
MST_STRM_GEN -- requirements
Module: mst_strm_gen

Interface
REQ-001 Parameter WIDTH, default 36: pre-fetch word width; generated data width is WIDTH-4 (32 at default).
REQ-002 Parameter LENBIT, default 16: width of the transfer-length and word-count fields.
REQ-003 The module SHALL have a single clock and a synchronous, active-low reset, on ports clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 gen_start  input  1  one-cycle start pulse.
REQ-007 gen_stop  input  1  one-cycle abort pulse.
REQ-008 gen_mode  input  2  pattern select: 0 increment, 1 PRBS-31, 2 walking-one, 3 constant; sampled at start.
REQ-009 gen_seed  input  WIDTH-4  first word or pattern seed; sampled at start.
REQ-010 gen_len  input  LENBIT  words per transfer; 0 means unbounded; sampled at start.
REQ-011 gen0req  input  1  word request from the pre-fetch stage.
REQ-012 gen0dat  output  WIDTH-4  generated data word (registered).
REQ-013 gen_busy  output  1  high while in RUN; drives the pre-fetch enable.
REQ-014 gen_done  output  1  one-cycle pulse at transfer end.
REQ-015 gen_cnt  output  LENBIT  words accepted in the current or last transfer.

Function
REQ-016 The block SHALL implement the states IDLE, RUN and DONE, with gen_busy = (state==RUN) taken from a register.
REQ-017 In IDLE, gen_start=1 with gen_stop=0 SHALL: latch mode, seed and length; clear gen_cnt; load the next-value register with the seed; and enter RUN.
REQ-018 In IDLE, when gen_start and gen_stop are both 1, gen_stop SHALL win and the state SHALL remain IDLE.
REQ-019 A word is accepted when gen0req=1 in RUN; on that edge, gen0dat <= next-value, next-value <= f(next-value), and gen_cnt <= gen_cnt+1.
REQ-020 This timing SHALL guarantee that gen0dat is valid in the cycle after gen0req (one-cycle request-to-data latency); the first word of a transfer equals the effective seed.
REQ-021 When gen0req=0 or the state is not RUN, gen0dat, next-value and gen_cnt SHALL hold.
REQ-022 f for increment mode SHALL be +1 modulo 2^(WIDTH-4).
REQ-023 f for PRBS-31 mode SHALL be a Fibonacci LFSR shift-left on bits [30:0] with feedback bit30 XOR bit27, zero-extended to the word width; a seed[30:0] of 0 SHALL be replaced by 1.
REQ-024 f for walking-one mode SHALL be a 1-bit rotate left; a seed of 0 SHALL be replaced by 1.
REQ-025 f for constant mode SHALL be identity.
REQ-026 With gen_len != 0, accepting the word at which gen_cnt+1 == gen_len SHALL move the state RUN->DONE on the same edge, so gen_busy is low in the following cycle.
REQ-027 With gen_len == 0, the transfer SHALL run until stopped; gen_cnt SHALL wrap modulo 2^LENBIT without ending the transfer.
REQ-028 gen_stop in RUN SHALL move the state to DONE; a word accepted in that same cycle SHALL still be counted and emitted.
REQ-029 The DONE state SHALL last one cycle, assert gen_done=1, and return to IDLE.
REQ-030 gen_start in RUN or DONE SHALL be ignored.
REQ-031 gen_cnt SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-032 rst_n=0 at a rising clk edge SHALL force the state to IDLE, gen0dat=0, next-value=0, gen_cnt=0, gen_busy=0 and gen_done=0, including mid-transfer.
REQ-033 No gen_done pulse SHALL be produced by a reset that aborts a transfer.

Structure
REQ-034 A shared package mst_strm_pkg SHALL hold the state encodings, the gen_mode encodings, the PRBS-31 tap positions and the default WIDTH/LENBIT.
REQ-035 Pattern stepping SHALL be a combinational sub-module mst_pat_step (inputs: mode, current value; output: next value); the FSM and counters SHALL be in mst_strm_gen.

Verification
REQ-036 Bench scenario 1: mode 0, seed 0x0000_0010, len 4, gen0req held high -> gen0dat = 0x10, 0x11, 0x12, 0x13 in the cycles after each request; gen_done is pulsed once; gen_cnt=4; gen_busy is low in the cycle after the 4th request.
REQ-037 Bench scenario 2: mode 1, seed 0 -> the first word is 0x0000_0001 and the second word is 0x0000_0002; the 32nd word matches a reference LFSR model.
REQ-038 Bench scenario 3: mode 2, seed 0x8000_0000, len 3 -> gen0dat = 0x8000_0000, 0x0000_0001, 0x0000_0002.
REQ-039 Bench scenario 4: len 0, gen0req toggling every other cycle, gen_stop asserted after 5 accepted words in a cycle with gen0req=1 -> gen_cnt=6, and gen_done is pulsed the next cycle.
REQ-040 Bench scenario 5: rst_n driven low for one cycle after 2 of 8 words -> all outputs are 0, the state is IDLE, and no gen_done pulse occurs; a later gen_start restarts from the seed.
REQ-041 Bench scenario 6: gen_start and gen_stop asserted together in IDLE -> gen_busy stays 0; gen_start asserted during RUN -> gen_cnt is not cleared.
